// File: rtl/mic_sample_capture.sv
`default_nettype none
// ============================================================================
// mic_sample_capture: SPI master for a 12-bit mic ADC, one sample per period.
// Revision: 1.0
// ============================================================================
module mic_sample_capture #(
  parameter int SAMPLE_DIV = 5000,
  parameter int SCLK_HALF  = 25
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic        mic_miso,
  output logic        mic_sclk,
  output logic        mic_cs_n,
  output logic [11:0] raw_sample,
  output logic [9:0]  wave_sample,
  output logic        sample_valid,
  output logic        clk_sample,
  output logic        busy
);

  localparam int TW = $clog2(SAMPLE_DIV);
  localparam int HW = $clog2(SCLK_HALF + 1);
  localparam int CW = $clog2(SAMPLE_DIV / 2 + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(SAMPLE_DIV - 1);
  localparam logic [HW-1:0] HALF_LAST = HW'(SCLK_HALF - 1);
  localparam logic [CW-1:0] CKS_LAST  = CW'(SAMPLE_DIV / 2 - 1);
  localparam logic [4:0]    BITS_LAST = 5'd16;

  typedef enum logic [1:0] {IDLE, SETUP, SHIFT, DONE} state_t;

  state_t          state, state_nx;
  logic [TW-1:0]   tick_cnt;
  logic [HW-1:0]   half_cnt, half_nx;
  logic [4:0]      bit_cnt, bit_nx;
  logic [15:0]     shift, shift_nx;
  logic [11:0]     raw_nx;
  logic            sclk_nx, cs_nx, busy_nx, valid_nx;
  logic [CW-1:0]   cks_cnt;
  logic            tick;
  logic            unused_lead_bits;

  assign tick             = (tick_cnt == '0);
  assign wave_sample      = raw_sample[11:2];
  assign unused_lead_bits = ^shift[15:12];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tick_cnt <= '0;
    end else if (tick_cnt == TICK_LAST) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      half_cnt     <= '0;
      bit_cnt      <= '0;
      shift        <= '0;
      raw_sample   <= 12'h800;
      mic_sclk     <= 1'b1;
      mic_cs_n     <= 1'b1;
      busy         <= 1'b0;
      sample_valid <= 1'b0;
    end else begin
      state        <= state_nx;
      half_cnt     <= half_nx;
      bit_cnt      <= bit_nx;
      shift        <= shift_nx;
      raw_sample   <= raw_nx;
      mic_sclk     <= sclk_nx;
      mic_cs_n     <= cs_nx;
      busy         <= busy_nx;
      sample_valid <= valid_nx;
    end
  end

  always_comb begin
    state_nx = state;
    half_nx  = half_cnt;
    bit_nx   = bit_cnt;
    shift_nx = shift;
    raw_nx   = raw_sample;
    sclk_nx  = mic_sclk;
    cs_nx    = mic_cs_n;
    busy_nx  = busy;
    valid_nx = 1'b0;
    case (state)
      IDLE: begin
        if (tick && enable) begin
          state_nx = SETUP;
          cs_nx    = 1'b0;
          busy_nx  = 1'b1;
          half_nx  = '0;
          bit_nx   = '0;
        end
      end
      SETUP: begin
        if (half_cnt == HALF_LAST) begin
          half_nx  = '0;
          sclk_nx  = 1'b0;
          state_nx = SHIFT;
        end else begin
          half_nx = half_cnt + 1'b1;
        end
      end
      SHIFT: begin
        if (half_cnt == HALF_LAST) begin
          half_nx = '0;
          if (!mic_sclk) begin
            // Rising SCLK edge: ADC data has been stable since the fall.
            sclk_nx  = 1'b1;
            shift_nx = {shift[14:0], mic_miso};
            bit_nx   = bit_cnt + 5'd1;
          end else if (bit_cnt == BITS_LAST) begin
            state_nx = DONE;
            cs_nx    = 1'b1;
            raw_nx   = shift[11:0];
            valid_nx = 1'b1;
          end else begin
            sclk_nx = 1'b0;
          end
        end else begin
          half_nx = half_cnt + 1'b1;
        end
      end
      DONE: begin
        state_nx = IDLE;
        busy_nx  = 1'b0;
        bit_nx   = '0;
        half_nx  = '0;
      end
      default: state_nx = IDLE;
    endcase
  end

  // clk_sample rises the cycle after sample_valid and holds for half a period.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sample <= 1'b0;
      cks_cnt    <= '0;
    end else if (sample_valid) begin
      clk_sample <= 1'b1;
      cks_cnt    <= '0;
    end else if (clk_sample) begin
      if (cks_cnt == CKS_LAST) begin
        clk_sample <= 1'b0;
      end else begin
        cks_cnt <= cks_cnt + 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mic_sample_capture.sv
`default_nettype none
// tb_mic_sample_capture: directed frames through a behavioural ADC, two parameter sets.
module tb_mic_sample_capture;

  logic clk = 1'b0;
  logic rst_n, enable;
  logic miso1 = 1'b0, miso2 = 1'b0;
  logic sclk1, cs1, valid1, cks1, busy1;
  logic sclk2, cs2, valid2, cks2, busy2;
  logic [11:0] raw1, raw2;
  logic [9:0]  wave1, wave2;

  always #5 clk = ~clk;

  mic_sample_capture #(.SAMPLE_DIV(100), .SCLK_HALF(2)) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mic_miso(miso1),
    .mic_sclk(sclk1), .mic_cs_n(cs1), .raw_sample(raw1), .wave_sample(wave1),
    .sample_valid(valid1), .clk_sample(cks1), .busy(busy1)
  );

  mic_sample_capture #(.SAMPLE_DIV(104), .SCLK_HALF(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .enable(enable), .mic_miso(miso2),
    .mic_sclk(sclk2), .mic_cs_n(cs2), .raw_sample(raw2), .wave_sample(wave2),
    .sample_valid(valid2), .clk_sample(cks2), .busy(busy2)
  );

  // Cycle 0 is the tick cycle right after reset release.
  int cyc = 0;
  always @(posedge clk) if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  // ADC models: next bit presented on every SCLK fall while selected.
  logic [15:0] word1, word2;
  int idx1 = 15, idx2 = 15;
  always @(negedge cs1) idx1 = 15;
  always @(negedge sclk1) if (!cs1 && idx1 >= 0) begin miso1 = word1[idx1]; idx1 = idx1 - 1; end
  always @(negedge cs2) idx2 = 15;
  always @(negedge sclk2) if (!cs2 && idx2 >= 0) begin miso2 = word2[idx2]; idx2 = idx2 - 1; end

  int cs_fall1 = 0, cs_low1 = 0, rises1 = 0, nvalid1 = 0;
  int cks_rise1 = 0, cks_run1 = 0, cks_last1 = 0;
  logic p_cs1 = 1'b1, p_sclk1 = 1'b1, p_cks1 = 1'b0;
  always @(negedge clk) begin
    if (!cs1 && p_cs1) begin cs_fall1 = cyc; cs_low1 = 0; rises1 = 0; end
    if (!cs1) cs_low1++;
    if (sclk1 && !p_sclk1 && !cs1) rises1++;
    if (valid1) nvalid1++;
    if (cks1) begin
      if (!p_cks1) begin cks_rise1 = cyc; cks_run1 = 1; end
      else cks_run1++;
    end else if (p_cks1) cks_last1 = cks_run1;
    p_cs1 = cs1; p_sclk1 = sclk1; p_cks1 = cks1;
  end

  int rises2 = 0, first2 = 0, last2 = 0, nvalid2 = 0;
  int v2a = 0, v2b = 0, f_rises2 = 0, f_first2 = 0, f_last2 = 0;
  logic [11:0] raw2a = '0;
  logic p_cs2 = 1'b1, p_sclk2 = 1'b1;
  always @(negedge clk) begin
    if (!cs2 && p_cs2) rises2 = 0;
    if (sclk2 && !p_sclk2 && !cs2) begin
      rises2++;
      if (rises2 == 1) first2 = cyc;
      last2 = cyc;
    end
    if (valid2) begin
      nvalid2++;
      if (nvalid2 == 1) begin
        v2a = cyc; raw2a = raw2; f_rises2 = rises2; f_first2 = first2; f_last2 = last2;
      end else if (nvalid2 == 2) v2b = cyc;
    end
    p_cs2 = cs2; p_sclk2 = sclk2;
  end

  int n_checks = 0, n_fail = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_valid1(output int at);
    logic found;
    found = 1'b0;
    at = -1;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (valid1) begin found = 1'b1; at = cyc; end
    end
    check("valid_seen", {31'd0, found}, 32'd1);
  endtask

  task automatic wait_cyc(input int n);
    for (int i = 0; i < 3000 && cyc != n; i++) @(negedge clk);
    check("reach_cycle", cyc, n);
  endtask

  logic [15:0] wl [4] = '{16'h0FFF, 16'h0000, 16'hF003, 16'h0555};
  logic [11:0] rl [4] = '{12'hFFF, 12'h000, 12'h003, 12'h555};
  logic [9:0]  vl [4] = '{10'd1023, 10'd0, 10'd0, 10'h155};

  initial begin
    int at, prev, n0;
    logic seen_cs;
    rst_n = 1'b0; enable = 1'b0; word1 = 16'h0ABC; word2 = 16'h0A5C;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs1, 1'b1);
    check("rst_sclk", sclk1, 1'b1);
    check("rst_raw", raw1, 12'h800);
    check("rst_wave", wave1, 10'd512);
    check("rst_valid", valid1, 1'b0);
    check("rst_clk_sample", cks1, 1'b0);
    check("rst_busy", busy1, 1'b0);

    enable = 1'b1; rst_n = 1'b1;
    wait_valid1(at);
    check("f1_valid_cycle", at, 67);
    check("f1_raw", raw1, 12'hABC);
    check("f1_wave", wave1, 10'h2AF);
    check("f1_cs_high_at_valid", cs1, 1'b1);
    check("f1_busy_at_valid", busy1, 1'b1);
    @(negedge clk);
    check("f1_busy_after", busy1, 1'b0);
    check("f1_valid_one_cycle", valid1, 1'b0);
    check("f1_clk_sample_rise", cks1, 1'b1);
    check("f1_cs_fall_cycle", cs_fall1, 1);
    check("f1_cs_low_cycles", cs_low1, 66);
    check("f1_sclk_rises", rises1, 16);
    prev = at;

    for (int f = 0; f < 4; f++) begin
      word1 = wl[f];
      wait_valid1(at);
      check("period", at - prev, 100);
      check("raw", raw1, rl[f]);
      check("wave", wave1, vl[f]);
      check("clk_sample_rise", cks_rise1, prev + 1);
      check("clk_sample_width", cks_last1, 50);
      prev = at;
      @(negedge clk);
    end

    check("p2_valid1_cycle", v2a, 100);
    check("p2_valid2_cycle", v2b, 204);
    check("p2_raw", raw2a, 12'hA5C);
    check("p2_rises", f_rises2, 16);
    check("p2_first_rise", f_first2, 7);
    check("p2_last_rise", f_last2, 97);

    word1 = 16'h0123;
    wait_cyc(510);
    enable = 1'b0;
    wait_valid1(at);
    check("drop_en_valid_cycle", at, 567);
    check("drop_en_raw", raw1, 12'h123);
    check("drop_en_wave", wave1, 10'h048);
    @(negedge clk);
    n0 = nvalid1;
    seen_cs = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!cs1) seen_cs = 1'b1;
    end
    check("idle_no_valid", nvalid1, n0);
    check("idle_no_cs", {31'd0, seen_cs}, 32'd0);
    check("idle_clk_sample", cks1, 1'b0);
    check("idle_sclk", sclk1, 1'b1);
    check("idle_wave_hold", wave1, 10'h048);

    wait_cyc(880);
    enable = 1'b1;
    wait_cyc(920);
    check("mid_cs_low", cs1, 1'b0);
    check("mid_sclk_low", sclk1, 1'b0);
    rst_n = 1'b0;
    #1;
    check("async_cs_n", cs1, 1'b1);
    check("async_sclk", sclk1, 1'b1);
    check("async_wave", wave1, 10'd512);
    check("async_busy", busy1, 1'b0);
    word1 = 16'h0DEF;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_valid1(at);
    check("post_rst_valid_cycle", at, 67);
    check("post_rst_raw", raw1, 12'hDEF);
    check("post_rst_wave", wave1, 10'h37B);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mic_sample_capture.md
Name: mic_sample_capture

Overview:
- SPI master for the 12-bit microphone ADC (16-SCLK frame: 4 leading zeros, then 12 data bits MSB first).
- Captures one sample per sample period and presents it as wave_sample[9:0] with a matching clk_sample, which the waveform display blocks store on posedge clk_sample.
- Sits between the mic Pmod pins and every display/zoom block; it is the producer for their sample-memory writers.

Parameters:
- SAMPLE_DIV, 5000, clk cycles per sample period (100 MHz / 5000 = 20 kHz); must satisfy SAMPLE_DIV >= 33*SCLK_HALF + 4.
- SCLK_HALF, 25, clk cycles per SCLK half-period (2 MHz SCLK at 100 MHz); must be >= 2.

Ports:
- clk  in  1  system clock; all logic is on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- enable  in  1  when 1, a conversion starts at each sample tick.
- mic_miso  in  1  ADC serial data.
- mic_sclk  out  1  SPI clock, idle high.
- mic_cs_n  out  1  ADC chip select, active low.
- raw_sample  out  12  last complete 12-bit conversion.
- wave_sample  out  10  raw_sample[11:2].
- sample_valid  out  1  one-cycle pulse when raw_sample/wave_sample update.
- clk_sample  out  1  sample-rate square wave; rises one cycle after each update.
- busy  out  1  high from mic_cs_n low until the cycle after mic_cs_n returns high.

Behaviour:
- Reset (async, immediate): mic_cs_n=1, mic_sclk=1, raw_sample=12'h800, wave_sample=10'd512 (midscale), sample_valid=0, clk_sample=0, busy=0, state=IDLE, all counters 0.
- Tick counter: counts 0..SAMPLE_DIV-1 and wraps; it free-runs regardless of enable. Tick = counter==0.
- FSM states: IDLE, SETUP, SHIFT, DONE.
- IDLE -> SETUP: on a tick with enable=1. In the next cycle (cycle 1), mic_cs_n=0 and busy=1.
- SETUP: hold for SCLK_HALF cycles, then mic_sclk falls (cycle 1+SCLK_HALF) and the FSM enters SHIFT.
- SHIFT: mic_sclk toggles every SCLK_HALF cycles.
  - On each clk edge where mic_sclk goes 0->1, shift mic_miso into a 16-bit shift register, MSB first.
  - Rise k (k=0..15) occurs at cycle 1+(2k+2)*SCLK_HALF.
  - After the 16th rise, mic_sclk stays high; wait SCLK_HALF cycles, then go to DONE.
- DONE, at cycle 1+33*SCLK_HALF (826 with defaults), in one cycle:
  - mic_cs_n=1.
  - raw_sample <= shift[11:0]; shift[15:12] is discarded unchecked.
  - wave_sample <= shift[11:2].
  - sample_valid=1.
  - Next cycle: state=IDLE, busy=0, sample_valid=0.
- clk_sample: goes to 1 in the cycle after sample_valid. It stays 1 for SAMPLE_DIV/2 cycles (integer division), then returns to 0. It does not toggle when no conversion completes.
- enable deasserted mid-conversion: the current frame completes and updates normally; no new frame starts.
- enable asserted mid-period: the first frame starts at the next tick.
- Ticks while not IDLE are ignored. The SAMPLE_DIV constraint makes this unreachable with legal parameters.
- rst_n asserted mid-frame: mic_cs_n and mic_sclk return high asynchronously, the partial frame is discarded, and outputs return to reset values.
- Width rules:
  - wave_sample is a pure truncation; no rounding and no offset.
  - No arithmetic saturation is needed.

Test Plan (sim params SAMPLE_DIV=100, SCLK_HALF=2 unless noted):
- ADC model drives 16'h0ABC (changes on SCLK fall) -> raw_sample=12'hABC, wave_sample=10'h2AF, sample_valid high exactly at cycle 67 after the tick, mic_cs_n low cycles 1..66, exactly 16 SCLK rises.
- Frames 16'h0FFF, then 16'h0000, then 16'hF003 -> wave_sample 1023, then 0, then 0; raw_sample 12'h003 for the last (leading bits ignored).
- enable=1 continuously for 5 frames -> sample_valid pulses exactly 100 cycles apart; clk_sample high 50 cycles starting 1 cycle after each pulse; default params give the first valid at cycle 826.
- enable=0 -> mic_cs_n=1, mic_sclk=1, no sample_valid, clk_sample=0, wave_sample holds its value. Drop enable at cycle 10 of a frame -> that frame completes and no further frames start.
- rst_n low at cycle 20 of a frame -> same-cycle mic_cs_n=1, mic_sclk=1, wave_sample=512. After release, the next tick starts a clean frame with correct data.
- Parameter check SCLK_HALF=3, SAMPLE_DIV=104 -> the frame ends at cycle 100 and SCLK half-periods are 3 cycles with no missed ticks.
